// File: rtl/fpa_pipe.sv
// ============================================================================
//  Module   : fpa_pipe
//  Purpose  : Three-stage pipelined floating-point adder/subtractor with a
//             valid/ready stream interface and round-to-nearest-even.
//             Stages: align -> add -> normalise/round (output register).
//             Optional macro FPA_PIPE_FLAGS_EN adds the 4-bit flags port
//             {invalid, overflow, underflow, inexact}.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpa_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] number_A,
  input  logic [W-1:0] number_B,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FPA_PIPE_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  // Extended mantissa: hidden + fraction + guard + round + sticky
  localparam int E     = MAN_W + 4;
  localparam int LZW   = $clog2(E + 1);
  localparam int XW    = EXP_W + LZW + 2;
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam int SHMAX = MAN_W + 3;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Highest set bit position expressed as a leading-zero count
  function automatic logic [LZW-1:0] lzc(input logic [E-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(E);
    for (int i = 0; i < E; i++) begin
      if (v[i]) n = LZW'(E - 1 - i);
    end
    return n;
  endfunction

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------------------------------------------------------- unpack
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, any_nan, inf_cancel;

  assign sa = number_A[W-1];
  assign ea = number_A[W-2:MAN_W];
  assign ma = number_A[MAN_W-1:0];
  assign sb = number_B[W-1] ^ op;   // subtraction flips B's sign up front
  assign eb = number_B[W-2:MAN_W];
  assign mb = number_B[MAN_W-1:0];

  // Subnormals (exp == 0) are flushed to signed zero
  assign a_zero     = (ea == '0);
  assign b_zero     = (eb == '0);
  assign a_inf      = (ea == '1) && (ma == '0);
  assign b_inf      = (eb == '1) && (mb == '0);
  assign any_nan    = ((ea == '1) && (ma != '0)) || ((eb == '1) && (mb != '0));
  assign inf_cancel = a_inf && b_inf && (sa != sb);

  // ---------------------------------------------------------------- stage 1 comb
  logic             spec_d;
  logic [W-1:0]     spec_res_d;
  logic             sign_d, sub_d;
  logic [EXP_W-1:0] exp_d, diff;
  logic [E-1:0]     big_d, small_ext, small_d, sh;
  logic             lost;

  // Special-case detection, magnitude ordering and alignment shift
  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = '0;
    sign_d     = sa;
    exp_d      = ea;
    diff       = '0;
    big_d      = '0;
    small_ext  = '0;
    small_d    = '0;
    sh         = '0;
    lost       = 1'b0;
    sub_d      = sa ^ sb;

    if (any_nan || inf_cancel)  spec_res_d = QNAN;
    else if (a_inf)             spec_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_inf)             spec_res_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero && b_zero)  spec_res_d = {sa & sb, {(W-1){1'b0}}};
    else if (a_zero)            spec_res_d = {sb, eb, mb};
    else if (b_zero)            spec_res_d = {sa, ea, ma};
    else                        spec_d     = 1'b0;

    if ({ea, ma} >= {eb, mb}) begin
      sign_d    = sa;
      exp_d     = ea;
      diff      = ea - eb;
      big_d     = {1'b1, ma, 3'b000};
      small_ext = {1'b1, mb, 3'b000};
    end else begin
      sign_d    = sb;
      exp_d     = eb;
      diff      = eb - ea;
      big_d     = {1'b1, mb, 3'b000};
      small_ext = {1'b1, ma, 3'b000};
    end

    // Shifting past guard/round leaves only the sticky; the hidden bit makes it 1
    if (32'(diff) >= SHMAX) begin
      small_d = {{(E-1){1'b0}}, 1'b1};
    end else begin
      sh      = small_ext >> diff;
      lost    = |(small_ext & ~({E{1'b1}} << diff));
      small_d = {sh[E-1:1], sh[0] | lost};
    end
  end

  // ---------------------------------------------------------------- stage 1 regs
  logic             s1_valid, s1_spec, s1_sign, s1_sub;
  logic [W-1:0]     s1_spec_res;
  logic [EXP_W-1:0] s1_exp;
  logic [E-1:0]     s1_big, s1_small;
`ifdef FPA_PIPE_FLAGS_EN
  logic             s1_inv;
`endif

  // Align stage register; holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_spec     <= 1'b0;
      s1_spec_res <= '0;
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_exp      <= '0;
      s1_big      <= '0;
      s1_small    <= '0;
`ifdef FPA_PIPE_FLAGS_EN
      s1_inv      <= 1'b0;
`endif
    end else if (!stall) begin
      s1_valid    <= in_valid;
      s1_spec     <= spec_d;
      s1_spec_res <= spec_res_d;
      s1_sign     <= sign_d;
      s1_sub      <= sub_d;
      s1_exp      <= exp_d;
      s1_big      <= big_d;
      s1_small    <= small_d;
`ifdef FPA_PIPE_FLAGS_EN
      s1_inv      <= any_nan || inf_cancel;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [E:0] sum_d;
  // Larger magnitude is always the minuend, so the difference never goes negative
  assign sum_d = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

  logic             s2_valid, s2_spec, s2_sign;
  logic [W-1:0]     s2_spec_res;
  logic [EXP_W-1:0] s2_exp;
  logic [E:0]       s2_sum;
`ifdef FPA_PIPE_FLAGS_EN
  logic             s2_inv;
`endif

  // Add stage register; holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_res <= '0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
`ifdef FPA_PIPE_FLAGS_EN
      s2_inv      <= 1'b0;
`endif
    end else if (!stall) begin
      s2_valid    <= s1_valid;
      s2_spec     <= s1_spec;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_d;
`ifdef FPA_PIPE_FLAGS_EN
      s2_inv      <= s1_inv;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 3 comb
  logic [LZW-1:0]   lz;
  logic [E-1:0]     m_n;
  logic [XW-1:0]    e_n, e_r;
  logic             rnd_up, ovf, unf, inx;
  logic [MAN_W+1:0] m_r;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res_d;
`ifdef FPA_PIPE_FLAGS_EN
  logic [3:0]       flags_d;
`endif

  // Normalise, round to nearest even, then classify overflow/underflow
  always_comb begin
    lz  = '0;
    m_n = '0;
    e_n = '0;
    if (s2_sum[E]) begin
      m_n = {s2_sum[E:2], s2_sum[1] | s2_sum[0]};
      e_n = {{(XW-EXP_W){1'b0}}, s2_exp} + XW'(1);
    end else begin
      lz  = lzc(s2_sum[E-1:0]);
      m_n = s2_sum[E-1:0] << lz;
      e_n = {{(XW-EXP_W){1'b0}}, s2_exp} - {{(XW-LZW){1'b0}}, lz};
    end

    rnd_up = m_n[2] & (m_n[3] | m_n[1] | m_n[0]);
    m_r    = {1'b0, m_n[E-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (m_r[MAN_W+1]) begin
      e_r  = e_n + XW'(1);
      frac = m_r[MAN_W:1];
    end else begin
      e_r  = e_n;
      frac = m_r[MAN_W-1:0];
    end

    // e_r MSB set means the exponent went negative
    ovf   = !e_r[XW-1] && (e_r >= XW'(EMAX));
    unf   = e_r[XW-1] || (e_r == '0);
    inx   = |m_n[2:0];
    res_d = {s2_sign, e_r[EXP_W-1:0], frac};
`ifdef FPA_PIPE_FLAGS_EN
    flags_d = {1'b0, 1'b0, 1'b0, inx};
`endif

    if (s2_spec) begin
      res_d = s2_spec_res;
`ifdef FPA_PIPE_FLAGS_EN
      flags_d = {s2_inv, 3'b000};
`endif
    end else if (s2_sum == '0) begin
      res_d = '0;   // exact cancellation is +0
`ifdef FPA_PIPE_FLAGS_EN
      flags_d = 4'b0000;
`endif
    end else if (ovf) begin
      res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FPA_PIPE_FLAGS_EN
      flags_d = 4'b0101;
`endif
    end else if (unf) begin
      res_d = {s2_sign, {(W-1){1'b0}}};
`ifdef FPA_PIPE_FLAGS_EN
      flags_d = 4'b0011;
`endif
    end
  end

  // Output register; result and flags hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
`ifdef FPA_PIPE_FLAGS_EN
      flags     <= 4'b0000;
`endif
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result  <= res_d;
`ifdef FPA_PIPE_FLAGS_EN
        flags   <= flags_d;
`endif
      end
    end
  end

endmodule

`default_nettype wire
